uart_tx: RTL



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, line levels and bit-timing helper for the UART transmit path.
`default_nettype none
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int cycles_per_bit(input int clk_frq, input int baud);
    return clk_frq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous circular byte buffer with occupancy counter.
`default_nettype none
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 8N1 by default; 8E1 when UART_TX_PARITY_EN is defined.
`default_nettype none
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD       = 9600,
  parameter int CLK_FRQ    = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axiir,
  output logic       axiod,
  output logic       busy
);
  localparam int CPB = cycles_per_bit(CLK_FRQ, BAUD);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(CPB - 1);

  tx_state_t     state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [CW-1:0] cyc_cnt, cyc_n;
  logic          txd, txd_n;
  logic          last;
  logic          pop;
  logic [7:0]    fifo_dout;
  logic          full;
  logic          empty;
`ifdef UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (axiiv),
    .din   (axiid),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign last  = (cyc_cnt == LAST_CYC);
  assign axiir = !full;
  assign axiod = txd;
  assign busy  = (state != IDLE) || !empty;

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    txd_n   = txd;
    pop     = 1'b0;
    cyc_n   = last ? '0 : cyc_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        cyc_n = '0;
        txd_n = STOP_BIT;
      end
      START: if (last) begin
        state_n = DATA;
        txd_n   = shift[0];
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        bit_n   = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          txd_n   = par;
`else
          state_n = STOP;
          txd_n   = STOP_BIT;
`endif
        end else begin
          txd_n = shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) begin
        state_n = STOP;
        txd_n   = STOP_BIT;
      end
`endif
      STOP: if (last) begin
        state_n = IDLE;
        txd_n   = STOP_BIT;
      end
      default: begin
        state_n = IDLE;
        txd_n   = STOP_BIT;
      end
    endcase
    // A queued byte starts from IDLE or straight out of the last stop-bit cycle (no idle gap).
    if (((state == IDLE) || ((state == STOP) && last)) && !empty) begin
      pop     = 1'b1;
      shift_n = fifo_dout;
      bit_n   = '0;
      cyc_n   = '0;
      txd_n   = START_BIT;
      state_n = START;
`ifdef UART_TX_PARITY_EN
      par_n   = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      txd     <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      cyc_cnt <= cyc_n;
      txd     <= txd_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule
`default_nettype wire
